// File: rtl/eye_test_pkg.sv
// Shared encodings and frame constants for the eye-test controller.
// Optional feature macro used by the controller: EYE_TEST_FEEDBACK_EN.
package eye_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHOW     = 3'd1,
    ST_WAIT_KEY = 3'd2,
    ST_JUDGE    = 3'd3,
    ST_FEEDBACK = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic [2:0] MODE_BLANK = 3'd0;
  localparam logic [2:0] MODE_LEFT  = 3'd1;
  localparam logic [2:0] MODE_RIGHT = 3'd2;
  localparam logic [2:0] MODE_UP    = 3'd3;
  localparam logic [2:0] MODE_DOWN  = 3'd4;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Right-facing E, bit 7 of each row is the leftmost column; sizes 8/6/5/3.
  localparam logic [63:0] E_BITMAP [4] = '{
    64'hFF80_80FE_8080_80FF,
    64'h00FC_80F8_8080_FC00,
    64'h0000_F880_F080_F800,
    64'h0000_00E0_C0E0_0000
  };

  localparam logic [63:0] TICK_BITMAP  = 64'h0001_0204_8850_2000;
  localparam logic [63:0] CROSS_BITMAP = 64'h8142_2418_1824_4281;

endpackage

// File: rtl/eye_test_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1; exposes the two bits
// used to pick the symbol direction.
module eye_test_lfsr
  import eye_test_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [1:0] rnd_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign rnd_o = lfsr_q[1:0];

endmodule

// File: rtl/eye_test_ctrl.sv
// Tumbling-E eye test sequencer: shows a random-direction E, judges the key answer,
// adapts the symbol size. Define EYE_TEST_FEEDBACK_EN for a tick/cross frame after each answer.
module eye_test_ctrl
  import eye_test_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 10000000,
  parameter int unsigned TRIALS      = 10,
  parameter int unsigned RESP_CYCLES = 30000000,
  parameter int unsigned FB_CYCLES   = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  key_dir,
  output logic [2:0]  mode,
  output logic [63:0] DianZhen_Data,
  output logic [3:0]  score,
  output logic [1:0]  level,
  output logic        done,
  output state_t      dbg_state_o
);

  if (CLK_FREQ < 1 || TRIALS < 1 || TRIALS > 15 || RESP_CYCLES < 1 || FB_CYCLES < 1) begin : g_bad_params
    $error("eye_test_ctrl: parameter out of range");
  end

  // One down-counter serves both the response window and the feedback window.
  localparam int unsigned CNT_MAX = (RESP_CYCLES > FB_CYCLES) ? RESP_CYCLES : FB_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         key_q;
  logic [3:0]         edge_q, edge_d;
  logic [1:0]         dir_q, dir_d;
  logic [3:0]         trial_q, trial_d;
  logic [3:0]         score_q, score_d;
  logic [1:0]         level_q, level_d;
  logic [2:0]         mode_q, mode_d;
  logic [63:0]        data_q, data_d;
  logic               done_q, done_d;
  logic               armed_q;
  logic [1:0]         rnd;
  logic [3:0]         key_edge;
  logic               correct;

  eye_test_lfsr u_lfsr (
    .clk_i  (clk),
    .rst_ni (rst),
    .rnd_o  (rnd)
  );

  assign key_edge = key_dir & ~key_q;
  // Exactly one edge, on the key that matches the shown direction; timeout leaves edge_q zero.
  assign correct  = (edge_q == (4'b0001 << dir_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    dir_d   = dir_q;
    trial_d = trial_q;
    score_d = score_q;
    level_d = level_q;
    mode_d  = mode_q;
    data_d  = data_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE: begin
        mode_d = MODE_BLANK;
        done_d = 1'b0;
        if (start && armed_q) begin
          score_d = '0;
          level_d = '0;
          trial_d = '0;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        dir_d   = rnd;
        mode_d  = {1'b0, rnd} + 3'd1;
        data_d  = E_BITMAP[level_q];
        cnt_d   = CNT_W'(RESP_CYCLES - 1);
        edge_d  = '0;
        state_d = ST_WAIT_KEY;
      end
      ST_WAIT_KEY: begin
        if (|key_edge) begin
          edge_d  = key_edge;
          state_d = ST_JUDGE;
        end else if (cnt_q == '0) begin
          state_d = ST_JUDGE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_JUDGE: begin
        trial_d = trial_q + 4'd1;
        if (correct) begin
          score_d = score_q + 4'd1;
          level_d = (level_q == 2'd3) ? 2'd3 : level_q + 2'd1;
        end else begin
          level_d = (level_q == 2'd0) ? 2'd0 : level_q - 2'd1;
        end
`ifdef EYE_TEST_FEEDBACK_EN
        cnt_d   = CNT_W'(FB_CYCLES - 1);
        mode_d  = MODE_RIGHT;
        data_d  = correct ? TICK_BITMAP : CROSS_BITMAP;
        state_d = ST_FEEDBACK;
`else
        state_d = (trial_q == 4'(TRIALS - 1)) ? ST_DONE : ST_SHOW;
`endif
      end
`ifdef EYE_TEST_FEEDBACK_EN
      ST_FEEDBACK: begin
        if (cnt_q == '0) begin
          mode_d  = MODE_BLANK;
          data_d  = '0;
          state_d = (trial_q == 4'(TRIALS)) ? ST_DONE : ST_SHOW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      ST_DONE: begin
        mode_d = MODE_BLANK;
        done_d = 1'b1;
        if (start) begin
          score_d = '0;
          level_d = '0;
          trial_d = '0;
          done_d  = 1'b0;
          state_d = ST_SHOW;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      edge_q  <= '0;
      dir_q   <= '0;
      trial_q <= '0;
      score_q <= '0;
      level_q <= '0;
      mode_q  <= MODE_BLANK;
      data_q  <= '0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_dir;
      edge_q  <= edge_d;
      dir_q   <= dir_d;
      trial_q <= trial_d;
      score_q <= score_d;
      level_q <= level_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      done_q  <= done_d;
      armed_q <= 1'b1;
    end
  end

  assign mode          = mode_q;
  assign DianZhen_Data = data_q;
  assign score         = score_q;
  assign level         = level_q;
  assign done          = done_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_eye_test_ctrl.sv
// Bench for eye_test_ctrl: directed trials, judged results checked by a scoreboard monitor.
module tb_eye_test_ctrl;
  import eye_test_pkg::*;

  localparam int unsigned NTR  = 3;
  localparam int unsigned RESP = 100;
  localparam int unsigned FB   = 20;
  localparam logic [63:0] TICK_EXP  = 64'h0001_0204_8850_2000;
  localparam logic [63:0] CROSS_EXP = 64'h8142_2418_1824_4281;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  key_dir;
  logic [2:0]  mode;
  logic [63:0] DianZhen_Data;
  logic [3:0]  score;
  logic [1:0]  level;
  logic        done;
  state_t      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [69:0] exp_q[$];

  always #5 clk = ~clk;

  eye_test_ctrl #(
    .TRIALS      (NTR),
    .RESP_CYCLES (RESP),
    .FB_CYCLES   (FB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .key_dir       (key_dir),
    .mode          (mode),
    .DianZhen_Data (DianZhen_Data),
    .score         (score),
    .level         (level),
    .done          (done),
    .dbg_state_o   (dbg_state)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endfunction

  // Reference LFSR from the polynomial; matches the DUT value between edges.
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 8'hA5;
    else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // Monitor: a judged result appears the cycle after JUDGE; the shown direction the cycle after SHOW.
  state_t      prev_state = ST_IDLE;
  logic [2:0]  exp_mode   = '0;
  logic [69:0] mon_e;
  always @(negedge clk) begin
    if (rst && prev_state == ST_JUDGE) begin
      if (exp_q.size() == 0) begin
        check("judge_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("judge_score", 64'(score), 64'(mon_e[69:66]));
        check("judge_level", 64'(level), 64'(mon_e[65:64]));
`ifdef EYE_TEST_FEEDBACK_EN
        check("fb_mode", 64'(mode), 64'd2);
        check("fb_frame", DianZhen_Data, mon_e[63:0]);
`endif
      end
    end
    if (rst && prev_state == ST_SHOW) check("show_mode", 64'(mode), 64'(exp_mode));
    if (dbg_state == ST_SHOW) exp_mode = {1'b0, m_lfsr[1:0]} + 3'd1;
    prev_state = dbg_state;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_state(input state_t s, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (dbg_state == s) return;
      tick();
    end
    check(name, 64'(dbg_state), 64'(s));
  endtask

  // Press the key matching the displayed direction, then follow the post-judge sequence.
  task automatic press_correct(input logic [3:0] exp_score, input logic [1:0] exp_level,
                               input bit last);
    int idx;
    int cnt;
    idx = (mode >= 3'd1 && mode <= 3'd4) ? int'(mode) - 1 : 0;
    exp_q.push_back({exp_score, exp_level, TICK_EXP});
    key_dir = 4'b0001 << idx;
    tick();
    check("press_to_judge", 64'(dbg_state), 64'(ST_JUDGE));
    key_dir = 4'b0000;
    tick();
`ifdef EYE_TEST_FEEDBACK_EN
    cnt = 0;
    while (mode == 3'd2 && DianZhen_Data == TICK_EXP && cnt < 200) begin
      cnt++;
      tick();
    end
    check("fb_cycles", 64'(cnt), 64'(FB));
`else
    cnt = 0;
    check("next_after_judge", 64'(dbg_state), last ? 64'(ST_DONE) : 64'(ST_SHOW));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b0; start = 1'b0; key_dir = 4'b0000;
    repeat (3) tick();
    check("rst_mode", 64'(mode), 64'd0);
    check("rst_data", DianZhen_Data, 64'd0);
    check("rst_score", 64'(score), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b1;
    tick(); tick();

    // Run 1: correct, multi-key wrong, timeout with keys held from before WAIT_KEY.
    pulse_start();
    wait_state(ST_WAIT_KEY, 10, "run1_t1_wait");
    press_correct(4'd1, 2'd1, 1'b0);

    wait_state(ST_WAIT_KEY, 200, "run1_t2_wait");
    exp_q.push_back({4'd1, 2'd0, CROSS_EXP});
    key_dir = 4'b0011;
    tick();
    check("multi_to_judge", 64'(dbg_state), 64'(ST_JUDGE));
    key_dir = 4'b1111;

    wait_state(ST_WAIT_KEY, 200, "run1_t3_wait");
    exp_q.push_back({4'd1, 2'd0, CROSS_EXP});
    cnt = 0;
    while (dbg_state != ST_JUDGE && cnt < 150) begin
      cnt++;
      tick();
    end
    check("timeout_cycles", 64'(cnt), 64'(RESP));
    key_dir = 4'b0000;
    wait_state(ST_DONE, 200, "run1_done_wait");
    tick();
    check("run1_done", 64'(done), 64'd1);
    check("run1_score", 64'(score), 64'd1);
    check("run1_level", 64'(level), 64'd0);
    check("run1_mode", 64'(mode), 64'd0);

    // Run 2: restart from DONE, all correct, stray start mid-trial.
    pulse_start();
    check("restart_score", 64'(score), 64'd0);
    check("restart_level", 64'(level), 64'd0);
    check("restart_done", 64'(done), 64'd0);
    wait_state(ST_WAIT_KEY, 10, "run2_t1_wait");
    press_correct(4'd1, 2'd1, 1'b0);
    wait_state(ST_WAIT_KEY, 200, "run2_t2_wait");
    pulse_start();
    check("start_ignored_state", 64'(dbg_state), 64'(ST_WAIT_KEY));
    check("start_ignored_score", 64'(score), 64'd1);
    press_correct(4'd2, 2'd2, 1'b0);
    wait_state(ST_WAIT_KEY, 200, "run2_t3_wait");
    press_correct(4'd3, 2'd3, 1'b1);
    wait_state(ST_DONE, 200, "run2_done_wait");
    tick();
    check("run2_done", 64'(done), 64'd1);
    check("run2_score", 64'(score), 64'd3);
    check("run2_level", 64'(level), 64'd3);
    check("run2_mode", 64'(mode), 64'd0);

    // Run 3: restart clears, then reset in the middle of a trial.
    pulse_start();
    check("run3_score_clr", 64'(score), 64'd0);
    check("run3_level_clr", 64'(level), 64'd0);
    check("run3_done_clr", 64'(done), 64'd0);
    wait_state(ST_WAIT_KEY, 10, "run3_t1_wait");
    press_correct(4'd1, 2'd1, 1'b0);
    wait_state(ST_WAIT_KEY, 200, "run3_t2_wait");
    tick(); tick();
    rst = 1'b0;
    #2;
    check("midrst_mode", 64'(mode), 64'd0);
    check("midrst_data", DianZhen_Data, 64'd0);
    check("midrst_score", 64'(score), 64'd0);
    check("midrst_level", 64'(level), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    tick();
    check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b1;
    tick(); tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eye_test_ctrl.md
EYE_TEST_CTRL -- requirements
Module: eye_test_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 10000000, giving the clk frequency in Hz.
REQ-002 SHALL have parameter TRIALS, default 10, giving the trials per test (range 1..15).
REQ-003 SHALL have parameter RESP_CYCLES, default 30000000, giving the response timeout in clk cycles.
REQ-004 SHALL have parameter FB_CYCLES, default 5000000, giving the feedback display time in clk cycles.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: the only reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: single-cycle pulse that begins a test.
REQ-008 SHALL have port key_dir, input, 4 bits: debounced level keys {down,up,right,left} on bits [3:0].
REQ-009 SHALL have port mode, output, 3 bits: scanner mode (0 blank, 1 left, 2 right, 3 up, 4 down).
REQ-010 SHALL have port DianZhen_Data, output, 64 bits: frame to the 8x8 scanner; row r is bits [8r+7:8r].
REQ-011 SHALL have port score, output, 4 bits: number of correct answers.
REQ-012 SHALL have port level, output, 2 bits: current symbol size index (0 largest).
REQ-013 SHALL have port done, output, 1 bit: held high while the test is complete.

Function
REQ-014 SHALL use FSM states IDLE, SHOW, WAIT_KEY, JUDGE, FEEDBACK, DONE, one-hot or binary.
REQ-015 SHALL run an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) every cycle; it never holds 0.
REQ-016 SHALL, in IDLE, drive mode=0 and hold until start=1; start then clears score, level and the trial counter, and the FSM enters SHOW next cycle.
REQ-017 SHALL, in SHOW (1 cycle), latch dir=lfsr[1:0]+1, load E_BITMAP[level] into DianZhen_Data, set mode=dir and enter WAIT_KEY.
REQ-018 SHALL register key_dir once and detect a press as the rising edge of any bit.
REQ-019 SHALL, in WAIT_KEY, decrement a timeout counter from RESP_CYCLES-1; a press or counter=0 moves to JUDGE; a press and timeout in the same cycle count as a press.
REQ-020 SHALL judge the answer correct only when exactly one key edge occurs and it matches dir (bit dir-1); multiple simultaneous edges or a timeout are wrong.
REQ-021 SHALL, on correct, add 1 to score and to level (level saturates at 3); on wrong, subtract 1 from level (saturates at 0); score never decreases.
REQ-022 SHALL increment the trial counter in JUDGE; when it reaches TRIALS, go to DONE after feedback, else go to SHOW.
REQ-023 SHALL, in DONE, drive mode=0, done=1 and hold score and level; start restarts per REQ-016.
REQ-024 SHALL ignore start outside IDLE and DONE.
REQ-025 SHALL ignore key edges outside WAIT_KEY; a key already held on entering WAIT_KEY does not count until released and pressed again.
REQ-026 SHALL make all outputs registered, with 1-cycle latency from state entry.

Reset
REQ-027 SHALL, on rst=0, immediately force IDLE, mode=0, DianZhen_Data=0, score=0, level=0, done=0, trial counter=0 and LFSR=8'hA5, including mid-trial.
REQ-028 SHALL take no action in the cycle in which rst is released.

Configuration
REQ-029 SHALL, with EYE_TEST_FEEDBACK_EN defined, enter FEEDBACK after JUDGE, showing TICK_BITMAP (correct) or CROSS_BITMAP (wrong) with mode=2 for FB_CYCLES cycles.
REQ-030 SHALL, without EYE_TEST_FEEDBACK_EN, go straight from JUDGE to SHOW or DONE and omit the FEEDBACK state and its counter.

Structure
REQ-031 SHALL put the 64-bit constants E_BITMAP[0..3] (right-facing E, sizes 8/6/5/3), TICK_BITMAP, CROSS_BITMAP, the mode encodings and the state encodings in package eye_test_pkg.
REQ-032 SHALL implement the LFSR as sub-module eye_test_lfsr.

Verification
REQ-033 SHALL verify reset: assert rst=0 in WAIT_KEY -> next cycle mode=0, score=0, level=0, done=0.
REQ-034 SHALL verify a correct answer: with RESP_CYCLES=100, start, then press the key matching mode -> score=1 and level=1 one cycle after JUDGE.
REQ-035 SHALL verify timeout: with RESP_CYCLES=100 and no key -> JUDGE exactly 100 cycles after WAIT_KEY entry, score unchanged, level stays 0 (saturated).
REQ-036 SHALL verify multi-key: assert two key bits in the same cycle -> judged wrong and level decrements.
REQ-037 SHALL verify a full run: TRIALS=3, all answers correct -> done=1, score=3, level=3, mode=0; a further start clears everything.
REQ-038 SHALL verify both builds: with the macro, mode=2 and the tick frame for FB_CYCLES=20 cycles; without it, SHOW follows JUDGE on the next cycle.
